pwm_channel_conditioner: RTL

//  Consumes one RC-PWM decoder channel: an i_pwm_ready strobe plus a 16-bit pulse-width word.
//  - Word format: bit15 = guard error; bits14:0 = width in us.
//  - Validates each sample, clamps it and rescales it to a 0-based channel value.
//  - Enforces acquire/failsafe policy before values reach the flight-control registers.
//  - One instance per receiver channel, directly downstream of the decoder.

---
 rtl/pwm_pkg.sv | 31 +++
 rtl/ms_tick_gen.sv | 31 +++
 rtl/pwm_channel_conditioner.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants, state encoding and scaling helper for the PWM conditioner
//
// Purpose: common definitions imported by pwm_channel_conditioner.
//   GUARD_ERROR_BIT   bit of the decoder word that flags a guard error
//   DEFAULT_MIN_US    default lower clamp in us
//   DEFAULT_MAX_US    default upper clamp in us
//   pwm_state_e       FAILSAFE / ACQUIRE / TRACKING
//   clamp_scale()     clamp a width to [min,max] and rebase it to 0
package pwm_pkg;

  localparam int GUARD_ERROR_BIT = 15;
  localparam int DEFAULT_MIN_US  = 1000;
  localparam int DEFAULT_MAX_US  = 2000;

  typedef enum logic [1:0] {
    ST_FAILSAFE = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_TRACKING = 2'd2
  } pwm_state_e;

  function automatic logic [10:0] clamp_scale(input logic [14:0] width,
                                               input logic [14:0] min_us,
                                               input logic [14:0] max_us);
    logic [14:0] clamped;
    clamped = width;
    if (width < min_us) clamped = min_us;
    else if (width > max_us) clamped = max_us;
    return 11'(clamped - min_us);
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// rtl/ms_tick_gen.sv - free-running 1 ms tick divider
//
// Purpose: divides i_clk by CLOCK_FREQ/1000 and emits a 1-cycle tick per period.
// Ports:
//   i_clk     in   1  system clock
//   i_resetn  in   1  reset, asynchronous, active-low
//   o_tick    out  1  1-cycle pulse once per millisecond
module ms_tick_gen #(
  parameter int unsigned CLOCK_FREQ = 50000000
) (
  input  logic i_clk,
  input  logic i_resetn,
  output logic o_tick
);

  // CLOCK_FREQ is expected to be at least 1 kHz.
  localparam logic [31:0] DIV_LAST = 32'(CLOCK_FREQ / 1000 - 1);

  logic [31:0] count;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      count  <= '0;
      o_tick <= 1'b0;
    end else begin
      o_tick <= (count == DIV_LAST);
      count  <= (count == DIV_LAST) ? '0 : count + 32'd1;
    end
  end

endmodule

// File: rtl/pwm_channel_conditioner.sv
// rtl/pwm_channel_conditioner.sv - validates, clamps, rescales one RC-PWM channel with failsafe policy
//
// Purpose: consumes decoder samples, applies acquire/error/timeout policy and
// publishes a 0-based channel value. Optional macro PWM_AVG_EN adds a 4-sample
// moving average (output latency becomes 2 cycles).
// Ports:
//   i_clk        in   1   system clock
//   i_resetn     in   1   reset, asynchronous, active-low
//   i_pwm_ready  in   1   1-cycle strobe: i_pwm_value is new
//   i_pwm_value  in   16  bit15 guard error, bits14:0 width in us
//   o_valid      out  1   1-cycle strobe: o_channel updated
//   o_channel    out  11  conditioned value, 0..MAX_US-MIN_US
//   o_failsafe   out  1   1 = no trustworthy signal
//   o_err_count  out  8   total bad samples, saturating at 255
module pwm_channel_conditioner
  import pwm_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 50000000,
  parameter int unsigned MIN_US     = DEFAULT_MIN_US,
  parameter int unsigned MAX_US     = DEFAULT_MAX_US,
  parameter int unsigned ACQ_COUNT  = 4,
  parameter int unsigned ERR_LIMIT  = 3,
  parameter int unsigned TIMEOUT_MS = 100
) (
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic        i_pwm_ready,
  input  logic [15:0] i_pwm_value,
  output logic        o_valid,
  output logic [10:0] o_channel,
  output logic        o_failsafe,
  output logic [7:0]  o_err_count
);

  localparam logic [3:0]  ACQ_LAST   = 4'(ACQ_COUNT - 1);
  localparam logic [3:0]  ERR_LAST   = 4'(ERR_LIMIT - 1);
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_MS - 1);
  localparam logic [15:0] TIMER_MAX  = 16'(TIMEOUT_MS);

  pwm_state_e  state, state_n;
  logic [3:0]  good_run, good_run_n;
  logic [3:0]  bad_run, bad_run_n;
  logic [15:0] ms_timer;
  logic        tick;
  logic        good, bad, expire;
  logic        upd, go_fs;
  logic [10:0] ch;

  ms_tick_gen #(.CLOCK_FREQ(CLOCK_FREQ)) u_tick (
    .i_clk    (i_clk),
    .i_resetn (i_resetn),
    .o_tick   (tick)
  );

  assign good = i_pwm_ready & ~i_pwm_value[GUARD_ERROR_BIT];
  assign bad  = i_pwm_ready &  i_pwm_value[GUARD_ERROR_BIT];
  assign ch   = clamp_scale(i_pwm_value[14:0], 15'(MIN_US), 15'(MAX_US));

  // A good sample in the same cycle as the final tick wins: expiry is masked.
  assign expire = tick & ~good & (state != ST_FAILSAFE) & (ms_timer >= TIMER_LAST);

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state    <= ST_FAILSAFE;
      good_run <= '0;
      bad_run  <= '0;
    end else begin
      state    <= state_n;
      good_run <= good_run_n;
      bad_run  <= bad_run_n;
    end
  end

  always_comb begin
    state_n    = state;
    good_run_n = good_run;
    bad_run_n  = bad_run;
    upd        = 1'b0;
    go_fs      = 1'b0;
    case (state)
      ST_FAILSAFE: begin
        if (good) begin
          if (ACQ_LAST == 4'd0) begin
            state_n = ST_TRACKING;
            upd     = 1'b1;
          end else begin
            state_n    = ST_ACQUIRE;
            good_run_n = 4'd1;
          end
        end
      end
      ST_ACQUIRE: begin
        if (good) begin
          if (good_run >= ACQ_LAST) begin
            state_n    = ST_TRACKING;
            good_run_n = '0;
            upd        = 1'b1;
          end else begin
            good_run_n = good_run + 4'd1;
          end
        end else if (bad) begin
          good_run_n = '0;
        end
      end
      ST_TRACKING: begin
        if (good) begin
          upd       = 1'b1;
          bad_run_n = '0;
        end else if (bad) begin
          if (bad_run >= ERR_LAST) go_fs = 1'b1;
          else bad_run_n = bad_run + 4'd1;
        end
      end
      default: go_fs = 1'b1;
    endcase
    if (expire) go_fs = 1'b1;
    if (go_fs) begin
      state_n    = ST_FAILSAFE;
      good_run_n = '0;
      bad_run_n  = '0;
    end
  end

  // Timer saturates at TIMEOUT_MS so it holds after expiry.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      ms_timer    <= '0;
      o_err_count <= '0;
    end else begin
      if (good) ms_timer <= '0;
      else if (tick && ms_timer < TIMER_MAX) ms_timer <= ms_timer + 16'd1;
      if (bad && o_err_count != 8'hFF) o_err_count <= o_err_count + 8'd1;
    end
  end

`ifdef PWM_AVG_EN
  logic [10:0] hist [4];
  logic        upd_q, fs_q, clr_q;
  logic        enter_trk;
  logic [12:0] sum;

  assign enter_trk = (state != ST_TRACKING) && (state_n == ST_TRACKING);
  assign sum = 13'(hist[0]) + 13'(hist[1]) + 13'(hist[2]) + 13'(hist[3]);

  // Stage 1 updates the history; stage 2 publishes the average with the
  // failsafe flag delayed alongside it so both change in the same cycle.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      for (int i = 0; i < 4; i++) hist[i] <= '0;
      upd_q      <= 1'b0;
      fs_q       <= 1'b1;
      clr_q      <= 1'b0;
      o_valid    <= 1'b0;
      o_channel  <= '0;
      o_failsafe <= 1'b1;
    end else begin
      if (go_fs) begin
        for (int i = 0; i < 4; i++) hist[i] <= '0;
      end else if (enter_trk) begin
        for (int i = 0; i < 4; i++) hist[i] <= ch;
      end else if (good && state != ST_FAILSAFE) begin
        hist[0] <= ch;
        for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
      end
      upd_q      <= upd;
      fs_q       <= (state_n != ST_TRACKING);
      clr_q      <= go_fs;
      o_valid    <= upd_q & ~o_valid;
      o_failsafe <= fs_q;
      if (clr_q) o_channel <= '0;
      else if (upd_q) o_channel <= 11'(sum >> 2);
    end
  end
`else
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      o_valid    <= 1'b0;
      o_channel  <= '0;
      o_failsafe <= 1'b1;
    end else begin
      o_valid    <= upd & ~o_valid;
      o_failsafe <= (state_n != ST_TRACKING);
      if (go_fs) o_channel <= '0;
      else if (upd) o_channel <= ch;
    end
  end
`endif

endmodule
